cellnet_source_seq: RTL and testbench
=====================================

Name: cellnet_source_seq

Overview:
- Parametrised message source for cellnet bring-up and soak tests.
- Drives one 4-phase req/ack channel (o_addr/o_dat/o_req, i_ack) into a cellnet sink or router.
- Sweeps a configurable address range with configurable stride, and selects one of three data patterns.
- Sends a bounded or unbounded number of messages under start/stop control, with an optional idle gap between messages, and reports busy/done/sent status.

Parameters:
- MIN_ADDR, 1, first address of the sweep.
- MAX_ADDR, 1, last legal address of the sweep; MIN_ADDR <= MAX_ADDR.
- ADDR_STEP, 1, address increment per message; >= 1.
- IDLE_GAP, 0, clock cycles inserted between i_ack falling and the next o_req rising.
- ASZ, `ADDRESS_SIZE, address width.
- DSZ, `DATA_SIZE, data width.
- CNT_SZ, 16, width of the message-count limit and the sent counter.

Ports:
- i_clk  in  1  main clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle pulse that begins a run; ignored while o_busy=1.
- i_stop  in  1  one-cycle pulse requesting a graceful end of the run.
- i_mode  in  2  data pattern, captured at start: 0 round counter, 1 message index, 2 address echo, 3 treated as 0.
- i_num_msgs  in  CNT_SZ  messages per run, captured at start; 0 means unlimited.
- o_addr  out  ASZ  message address.
- o_dat  out  DSZ  message data.
- o_req  out  1  request, 4-phase.
- i_ack  in  1  acknowledge from the sink.
- o_busy  out  1  high from start acceptance until the run ends.
- o_done  out  1  set when a run ends; cleared by the next accepted i_start.
- o_sent  out  CNT_SZ  messages completed in the current or last run; wraps modulo 2^CNT_SZ.

Behaviour:
- Reset (asynchronous, active low):
  - State IDLE.
  - o_req=0 immediately, without waiting for a clock edge.
  - o_addr=MIN_ADDR, o_dat=0, o_busy=0, o_done=0, o_sent=0.
  - Round counter, gap counter and stop_pend cleared.
- All outputs are registered.
- States: IDLE, ARM, REQ, RELEASE, GAP.
- IDLE, on i_start:
  - Capture i_mode and i_num_msgs.
  - o_addr=MIN_ADDR, round=0, o_sent=0, o_done=0, o_busy=1.
  - o_dat = first-message value for the mode: 0 in modes 0 and 1, MIN_ADDR in mode 2.
  - Go to ARM.
- ARM: when i_ack=0, set o_req=1 and go to REQ. Otherwise wait in ARM.
- REQ:
  - o_addr and o_dat are held stable while o_req=1.
  - On i_ack=1: o_req<=0, o_sent<=o_sent+1, advance address and data, go to RELEASE.
- Address advance:
  - Compute o_addr+ADDR_STEP in ASZ+1 bits.
  - If the sum > MAX_ADDR: o_addr<=MIN_ADDR and round<=round+1.
  - Otherwise o_addr<=sum.
- Data advance, applied to the new message:
  - Mode 0: o_dat = new round value (DSZ bits, wrapping).
  - Mode 1: o_dat = new o_sent value, truncated or zero-extended to DSZ.
  - Mode 2: o_dat = new o_addr, zero-extended or truncated to DSZ.
- RELEASE: wait for i_ack=0, then take the first matching case:
  - Run ends if i_num_msgs!=0 and o_sent==i_num_msgs, or if stop_pend=1: go to IDLE with o_busy=0, o_done=1, stop_pend=0.
  - Else if IDLE_GAP==0: o_req<=1, go to REQ.
  - Else: load the gap counter and go to GAP.
- GAP: count IDLE_GAP cycles, then o_req<=1 and go to REQ.
- Timing with IDLE_GAP=0:
  - o_req falls on the edge after i_ack rises.
  - o_req rises on the edge after i_ack falls.
- i_stop:
  - Ignored in IDLE.
  - Otherwise sets stop_pend.
  - In ARM or GAP, the run ends on the next edge with no further request.
  - A request already in flight is never withdrawn; it completes, is counted, and the run ends after RELEASE.
- i_stop and i_ack rising in the same cycle while in REQ: the message is counted and the run ends after i_ack falls.
- i_start and i_stop in the same cycle while in IDLE: the start is accepted and the stop is ignored.
- MIN_ADDR==MAX_ADDR: every message uses that address and round increments on every message.
- Reset asserted mid-handshake: o_req drops asynchronously. The sink is responsible for its own reset.

Test Plan:
- MIN=1, MAX=3, STEP=1, mode 0, num=7, immediate ack sink -> addr sequence 1,2,3,1,2,3,1; dat 0,0,0,1,1,1,2; then o_done=1, o_sent=7, o_req stays 0.
- MIN=2, MAX=9, STEP=3, mode 2, num=5 -> addr 2,5,8,2,5; dat equals addr; wrap occurs after 8.
- Mode 1, num=0, sink acks 4 cycles late; i_stop asserted while o_req=1 -> that message is completed and counted, o_req never rises again, o_done=1, o_sent equals number of acks, addr/dat held stable during every req-high window.
- IDLE_GAP=3 -> exactly 3 cycles between i_ack falling and the next o_req rising; i_stop during GAP ends the run with no extra request.
- i_ack held high at i_start -> o_req stays 0 in ARM until i_ack falls, then rises one edge later; i_start pulses during the run are ignored.
- i_rst_n pulled low mid-REQ -> o_req=0 before the next clock edge; all outputs return to reset values; a fresh i_start restarts at MIN_ADDR with o_sent=0.

Source files
------------

// File: rtl/cellnet_source_seq_if.sv
`default_nettype none
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 8
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 8
`endif
// ============================================================================
// Module   : cellnet_source_seq_if
// Purpose  : 4-phase req/ack cellnet message channel (address + data).
// Revision : 1.0 - initial release
// ============================================================================
interface cellnet_source_seq_if #(
    parameter int ASZ = `ADDRESS_SIZE,
    parameter int DSZ = `DATA_SIZE
);
    logic [ASZ-1:0] addr;
    logic [DSZ-1:0] dat;
    logic           req;
    logic           ack;

    modport master (output addr, output dat, output req, input ack);
    modport slave  (input addr, input dat, input req, output ack);
endinterface
`default_nettype wire

// File: rtl/cellnet_source_seq.sv
`default_nettype none
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 8
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 8
`endif
// ============================================================================
// Module   : cellnet_source_seq
// Purpose  : Address-sweeping message source driving one 4-phase cellnet channel.
// Revision : 1.0 - initial release
// ============================================================================
module cellnet_source_seq #(
    parameter int MIN_ADDR  = 1,
    parameter int MAX_ADDR  = 1,
    parameter int ADDR_STEP = 1,
    parameter int IDLE_GAP  = 0,
    parameter int ASZ       = `ADDRESS_SIZE,
    parameter int DSZ       = `DATA_SIZE,
    parameter int CNT_SZ    = 16
) (
    input  wire logic              i_clk,
    input  wire logic              i_rst_n,
    input  wire logic              i_start,
    input  wire logic              i_stop,
    input  wire logic [1:0]        i_mode,
    input  wire logic [CNT_SZ-1:0] i_num_msgs,
    cellnet_source_seq_if.master   bus,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [CNT_SZ-1:0]      o_sent
);

    localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam logic [ASZ-1:0] c_min_addr = ASZ'(MIN_ADDR);
    localparam logic [DSZ-1:0] c_min_dat  = DSZ'(MIN_ADDR);
    localparam logic [ASZ:0]   c_max_addr = (ASZ+1)'(MAX_ADDR);
    localparam logic [ASZ:0]   c_step     = (ASZ+1)'(ADDR_STEP);
    localparam logic [GW-1:0]  c_gap_load = GW'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_REQ     = 3'd2,
        S_RELEASE = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    state_t            r_state;
    logic [ASZ-1:0]    r_addr;
    logic [DSZ-1:0]    r_dat;
    logic              r_req;
    logic              r_busy;
    logic              r_done;
    logic [CNT_SZ-1:0] r_sent;
    logic [DSZ-1:0]    r_round;
    logic [GW-1:0]     r_gap;
    logic              r_stop_pend;
    logic [1:0]        r_mode;
    logic [CNT_SZ-1:0] r_num;

    logic [ASZ:0]      w_sum;
    logic              w_wrap;
    logic [ASZ-1:0]    w_addr_next;
    logic [DSZ-1:0]    w_round_next;
    logic [CNT_SZ-1:0] w_sent_next;
    logic [DSZ-1:0]    w_dat_next;
    logic              w_stop;
    logic              w_limit;

    // One extra bit on the sum so a sweep near the top of the address space cannot alias.
    assign w_sum        = {1'b0, r_addr} + c_step;
    assign w_wrap       = (w_sum > c_max_addr);
    assign w_addr_next  = w_wrap ? c_min_addr : w_sum[ASZ-1:0];
    assign w_round_next = w_wrap ? (r_round + DSZ'(1)) : r_round;
    assign w_sent_next  = r_sent + CNT_SZ'(1);
    assign w_stop       = i_stop | r_stop_pend;
    assign w_limit      = (r_num != '0) && (r_sent == r_num);

    always_comb begin
        w_dat_next = w_round_next;
        case (r_mode)
            2'd1:    w_dat_next = DSZ'(w_sent_next);
            2'd2:    w_dat_next = DSZ'(w_addr_next);
            default: w_dat_next = w_round_next;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= c_min_addr;
            r_dat       <= '0;
            r_req       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sent      <= '0;
            r_round     <= '0;
            r_gap       <= '0;
            r_stop_pend <= 1'b0;
            r_mode      <= 2'd0;
            r_num       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_mode      <= (i_mode == 2'd3) ? 2'd0 : i_mode;
                        r_num       <= i_num_msgs;
                        r_addr      <= c_min_addr;
                        r_dat       <= (i_mode == 2'd2) ? c_min_dat : '0;
                        r_round     <= '0;
                        r_sent      <= '0;
                        r_done      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_stop_pend <= 1'b0;
                        r_state     <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (w_stop) begin
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_stop_pend <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (!bus.ack) begin
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    // An in-flight request is never withdrawn; a stop only ends the run later.
                    if (i_stop) r_stop_pend <= 1'b1;
                    if (bus.ack) begin
                        r_req   <= 1'b0;
                        r_sent  <= w_sent_next;
                        r_addr  <= w_addr_next;
                        r_round <= w_round_next;
                        r_dat   <= w_dat_next;
                        r_state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (bus.ack) begin
                        if (i_stop) r_stop_pend <= 1'b1;
                    end else if (w_limit || w_stop) begin
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_stop_pend <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (IDLE_GAP == 0) begin
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end else begin
                        r_gap   <= c_gap_load;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (w_stop) begin
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_stop_pend <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (r_gap == '0) begin
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end else begin
                        r_gap <= r_gap - GW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.addr = r_addr;
    assign bus.dat  = r_dat;
    assign bus.req  = r_req;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_sent   = r_sent;

endmodule
`default_nettype wire

// File: tb/tb_cellnet_source_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cellnet_source_seq
// Purpose  : Directed self-checking bench; two sources (stride-1 no-gap, stride-3 gap-3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cellnet_source_seq;
    localparam int ASZ = 8;
    localparam int DSZ = 8;
    localparam int CNT = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic mon_clr;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   t;
    int   e[$];

    logic a_start, a_stop, a_busy, a_done, a_hold;
    logic [1:0] a_mode;
    logic [CNT-1:0] a_num, a_sent;
    int a_dly, a_cnt = 0;
    logic [7:0] a_addr_q[$], a_dat_q[$];
    int a_rises = 0, a_acks = 0, a_unstable = 0, a_idle = 0, a_gmin = 1000, a_gmax = 0;
    logic a_preq = 1'b0, a_pack = 1'b0;
    logic [7:0] a_paddr = '0, a_pdat = '0;

    logic b_start, b_stop, b_busy, b_done;
    logic [1:0] b_mode;
    logic [CNT-1:0] b_num, b_sent;
    int b_dly, b_cnt = 0;
    logic [7:0] b_addr_q[$], b_dat_q[$];
    int b_rises = 0, b_acks = 0, b_unstable = 0, b_idle = 0, b_gmin = 1000, b_gmax = 0;
    logic b_preq = 1'b0, b_pack = 1'b0;
    logic [7:0] b_paddr = '0, b_pdat = '0;

    cellnet_source_seq_if #(.ASZ(ASZ), .DSZ(DSZ)) a_if ();
    cellnet_source_seq_if #(.ASZ(ASZ), .DSZ(DSZ)) b_if ();

    cellnet_source_seq #(
        .MIN_ADDR(1), .MAX_ADDR(3), .ADDR_STEP(1), .IDLE_GAP(0),
        .ASZ(ASZ), .DSZ(DSZ), .CNT_SZ(CNT)
    ) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start), .i_stop(a_stop),
        .i_mode(a_mode), .i_num_msgs(a_num), .bus(a_if),
        .o_busy(a_busy), .o_done(a_done), .o_sent(a_sent)
    );

    cellnet_source_seq #(
        .MIN_ADDR(2), .MAX_ADDR(9), .ADDR_STEP(3), .IDLE_GAP(3),
        .ASZ(ASZ), .DSZ(DSZ), .CNT_SZ(CNT)
    ) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_stop(b_stop),
        .i_mode(b_mode), .i_num_msgs(b_num), .bus(b_if),
        .o_busy(b_busy), .o_done(b_done), .o_sent(b_sent)
    );

    // Sinks answer 2 time units after the edge; a_hold pins ack high.
    always begin
        @(posedge clk);
        #2;
        if (a_hold) a_if.ack = 1'b1;
        else if (!a_if.req) begin a_if.ack = 1'b0; a_cnt = 0; end
        else if (!a_if.ack) begin
            if (a_cnt >= a_dly) a_if.ack = 1'b1;
            else a_cnt++;
        end
    end

    always begin
        @(posedge clk);
        #2;
        if (!b_if.req) begin b_if.ack = 1'b0; b_cnt = 0; end
        else if (!b_if.ack) begin
            if (b_cnt >= b_dly) b_if.ack = 1'b1;
            else b_cnt++;
        end
    end

    // Idle gap = sampled cycles with req and ack both low before req rises (IDLE_GAP+1 with these sinks).
    always @(negedge clk) begin
        if (mon_clr) begin
            a_addr_q.delete(); a_dat_q.delete();
            a_rises = 0; a_acks = 0; a_gmin = 1000; a_gmax = 0;
        end else begin
            if (a_if.req && !a_preq) begin
                if (a_rises > 0) begin
                    if (a_idle < a_gmin) a_gmin = a_idle;
                    if (a_idle > a_gmax) a_gmax = a_idle;
                end
                a_addr_q.push_back(a_if.addr);
                a_dat_q.push_back(a_if.dat);
                a_rises++;
            end
            if (a_if.req && a_preq && (a_if.addr !== a_paddr || a_if.dat !== a_pdat)) a_unstable++;
            if (a_if.ack && !a_pack) a_acks++;
        end
        a_idle = (!a_if.req && !a_if.ack) ? a_idle + 1 : 0;
        a_preq = a_if.req; a_pack = a_if.ack; a_paddr = a_if.addr; a_pdat = a_if.dat;
    end

    always @(negedge clk) begin
        if (mon_clr) begin
            b_addr_q.delete(); b_dat_q.delete();
            b_rises = 0; b_acks = 0; b_gmin = 1000; b_gmax = 0;
        end else begin
            if (b_if.req && !b_preq) begin
                if (b_rises > 0) begin
                    if (b_idle < b_gmin) b_gmin = b_idle;
                    if (b_idle > b_gmax) b_gmax = b_idle;
                end
                b_addr_q.push_back(b_if.addr);
                b_dat_q.push_back(b_if.dat);
                b_rises++;
            end
            if (b_if.req && b_preq && (b_if.addr !== b_paddr || b_if.dat !== b_pdat)) b_unstable++;
            if (b_if.ack && !b_pack) b_acks++;
        end
        b_idle = (!b_if.req && !b_if.ack) ? b_idle + 1 : 0;
        b_preq = b_if.req; b_pack = b_if.ack; b_paddr = b_if.addr; b_pdat = b_if.dat;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_q(input string tag, input logic [7:0] q[$], input int ex[$]);
        chk({tag, "_len"}, q.size(), ex.size());
        foreach (ex[i])
            chk($sformatf("%s[%0d]", tag, i), (i < q.size()) ? 32'(q[i]) : 32'hFFFF_FFFF, ex[i]);
    endtask

    task automatic clr_mon();
        @(negedge clk); mon_clr = 1'b1;
        @(negedge clk); mon_clr = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        int k = 0;
        while (a_done !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        chk(tag, a_done, 1);
    endtask

    task automatic wait_done_b(input string tag);
        int k = 0;
        while (b_done !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        chk(tag, b_done, 1);
    endtask

    initial begin
        rst_n = 1'b0; mon_clr = 1'b0;
        a_start = 0; a_stop = 0; a_mode = 0; a_num = 0; a_dly = 0; a_hold = 0;
        b_start = 0; b_stop = 0; b_mode = 0; b_num = 0; b_dly = 0;
        repeat (3) @(negedge clk);
        chk("rst_a_req", a_if.req, 0);
        chk("rst_a_addr", a_if.addr, 1);
        chk("rst_a_dat", a_if.dat, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_done", a_done, 0);
        chk("rst_a_sent", a_sent, 0);
        chk("rst_b_addr", b_if.addr, 2);
        @(negedge clk); rst_n = 1'b1;

        // Stride-1 sweep, round-counter data, stray start mid-run
        clr_mon();
        a_mode = 2'd0; a_num = 16'd7; a_dly = 0;
        a_start = 1'b1; @(negedge clk); a_start = 1'b0;
        chk("t1_busy", a_busy, 1);
        chk("t1_sent0", a_sent, 0);
        repeat (5) @(negedge clk);
        a_start = 1'b1; @(negedge clk); a_start = 1'b0;
        wait_done_a("t1_done");
        repeat (6) @(negedge clk);
        chk("t1_sent", a_sent, 7);
        chk("t1_busy_end", a_busy, 0);
        chk("t1_req_end", a_if.req, 0);
        chk("t1_rises", a_rises, 7);
        chk("t1_gap_min", a_gmin, 1);
        chk("t1_gap_max", a_gmax, 1);
        e = '{1, 2, 3, 1, 2, 3, 1}; chk_q("t1_addr", a_addr_q, e);
        e = '{0, 0, 0, 1, 1, 1, 2}; chk_q("t1_dat", a_dat_q, e);

        // Unlimited run, index data, slow sink, stop while a request is in flight
        clr_mon();
        a_mode = 2'd1; a_num = 16'd0; a_dly = 4;
        @(negedge clk); a_start = 1'b1; @(negedge clk); a_start = 1'b0;
        t = 0; while (a_sent != 16'd3 && t < 400) begin @(negedge clk); t++; end
        chk("t3_reach3", a_sent, 3);
        t = 0; while (a_if.req !== 1'b1 && t < 400) begin @(negedge clk); t++; end
        chk("t3_req4", a_if.req, 1);
        a_stop = 1'b1; @(negedge clk); a_stop = 1'b0;
        wait_done_a("t3_done");
        repeat (12) @(negedge clk);
        chk("t3_sent", a_sent, 4);
        chk("t3_acks", a_acks, 4);
        chk("t3_rises", a_rises, 4);
        chk("t3_busy", a_busy, 0);
        chk("t3_stable", a_unstable, 0);
        e = '{1, 2, 3, 1}; chk_q("t3_addr", a_addr_q, e);
        e = '{0, 1, 2, 3}; chk_q("t3_dat", a_dat_q, e);

        // Ack held high at start: request waits in ARM
        a_hold = 1'b1; a_dly = 0;
        clr_mon();
        a_mode = 2'd1; a_num = 16'd2;
        a_start = 1'b1; @(negedge clk); a_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_arm_req", a_if.req, 0);
        chk("t5_arm_busy", a_busy, 1);
        a_hold = 1'b0;
        @(negedge clk);
        chk("t5_ack_low", a_if.ack, 0);
        chk("t5_req_still0", a_if.req, 0);
        @(negedge clk);
        chk("t5_req_rise", a_if.req, 1);
        a_start = 1'b1; @(negedge clk); a_start = 1'b0;
        wait_done_a("t5_done");
        repeat (6) @(negedge clk);
        chk("t5_sent", a_sent, 2);
        e = '{1, 2}; chk_q("t5_addr", a_addr_q, e);
        e = '{0, 1}; chk_q("t5_dat", a_dat_q, e);

        // Asynchronous reset mid-request, then a fresh run from MIN_ADDR
        clr_mon();
        a_mode = 2'd2; a_num = 16'd0; a_dly = 10;
        a_start = 1'b1; @(negedge clk); a_start = 1'b0;
        t = 0; while (a_sent != 16'd2 && t < 400) begin @(negedge clk); t++; end
        t = 0; while (a_if.req !== 1'b1 && t < 400) begin @(negedge clk); t++; end
        chk("t6_req_before", a_if.req, 1);
        chk("t6_addr_before", a_if.addr, 3);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async_req", a_if.req, 0);
        chk("t6_addr", a_if.addr, 1);
        chk("t6_dat", a_if.dat, 0);
        chk("t6_busy", a_busy, 0);
        chk("t6_sent", a_sent, 0);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        clr_mon();
        a_mode = 2'd2; a_num = 16'd3; a_dly = 0;
        a_start = 1'b1; @(negedge clk); a_start = 1'b0;
        chk("t6_restart_sent", a_sent, 0);
        chk("t6_restart_busy", a_busy, 1);
        wait_done_a("t6_done");
        repeat (6) @(negedge clk);
        chk("t6_sent_end", a_sent, 3);
        e = '{1, 2, 3}; chk_q("t6_addr", a_addr_q, e);
        e = '{1, 2, 3}; chk_q("t6_dat", a_dat_q, e);

        // Stride-3 wrap, address-echo data, 3-cycle idle gap
        clr_mon();
        b_mode = 2'd2; b_num = 16'd5; b_dly = 0;
        b_start = 1'b1; @(negedge clk); b_start = 1'b0;
        wait_done_b("t2_done");
        repeat (6) @(negedge clk);
        chk("t2_sent", b_sent, 5);
        chk("t2_rises", b_rises, 5);
        chk("t2_gap_min", b_gmin, 4);
        chk("t2_gap_max", b_gmax, 4);
        chk("t2_req_end", b_if.req, 0);
        chk("t2_stable", b_unstable, 0);
        e = '{2, 5, 8, 2, 5}; chk_q("t2_addr", b_addr_q, e);
        chk_q("t2_dat", b_dat_q, e);

        // Start and stop together in IDLE, then stop during GAP
        clr_mon();
        b_mode = 2'd0; b_num = 16'd0;
        b_start = 1'b1; b_stop = 1'b1; @(negedge clk); b_start = 1'b0; b_stop = 1'b0;
        chk("t4_start_wins", b_busy, 1);
        t = 0; while (b_sent != 16'd2 && t < 400) begin @(negedge clk); t++; end
        chk("t4_reach2", b_sent, 2);
        @(negedge clk); b_stop = 1'b1;
        @(negedge clk); b_stop = 1'b0;
        wait_done_b("t4_done");
        repeat (12) @(negedge clk);
        chk("t4_sent", b_sent, 2);
        chk("t4_rises", b_rises, 2);
        chk("t4_req", b_if.req, 0);
        chk("t4_busy", b_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
